// File: rtl/vram_term_pkg.sv
// Shared types and constants for the Apple I terminal VRAM write controller.
package vram_term_pkg;
  localparam int DEF_COLS   = 40;
  localparam int DEF_ROWS   = 24;
  localparam int DEF_ADDR_W = 11;

  localparam logic [6:0] CHAR_CR    = 7'h0D;
  localparam logic [5:0] CHAR_SPACE = 6'h20;

  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, SCROLL} state_t;
endpackage

// File: rtl/vram_addr_map.sv
// Maps a logical (row, col) onto a physical VRAM address through the circular top-row offset.
module vram_addr_map
  import vram_term_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [4:0]        top_row,
  input  logic [4:0]        row,
  input  logic [5:0]        col,
  output logic [ADDR_W-1:0] addr
);
  logic [5:0] sum;
  logic [5:0] phys_row;

  // Both operands are below ROWS, so a single conditional subtract wraps the sum.
  always_comb begin
    sum      = {1'b0, top_row} + {1'b0, row};
    phys_row = (sum >= 6'(ROWS)) ? sum - 6'(ROWS) : sum;
    addr     = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(col);
  end
endmodule

// File: rtl/vram_term_ctrl.sv
// Terminal write controller: cursor, wrap, clear and circular scroll for the 6-bit VRAM.
// Optional `VRAM_TERM_CURSOR_EN adds the registered cursor_addr output.
module vram_term_ctrl
  import vram_term_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              clr,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic              vram_we,
  output logic [5:0]        vram_din,
  output logic [4:0]        top_row,
  output logic [4:0]        cursor_row,
  output logic [5:0]        cursor_col
`ifdef VRAM_TERM_CURSOR_EN
  ,
  output logic [ADDR_W-1:0] cursor_addr
`endif
);
  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic [ADDR_W-1:0] waddr_next, map_addr;
  logic [4:0]        top_next, row_next, map_row;
  logic [5:0]        col_next, map_col, din_next;
  logic              we_next;

  assign char_ready = (state == IDLE);

  // While scrolling the shared mapper addresses physical row top_row, swept by the counter.
  assign map_row = (state == SCROLL) ? 5'd0 : cursor_row;
  assign map_col = (state == SCROLL) ? cnt[5:0] : cursor_col;

  vram_addr_map #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_map (
    .top_row (top_row),
    .row     (map_row),
    .col     (map_col),
    .addr    (map_addr)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    top_next   = top_row;
    row_next   = cursor_row;
    col_next   = cursor_col;
    we_next    = 1'b0;
    waddr_next = vram_waddr;
    din_next   = vram_din;
    if (clr) begin
      state_next = CLEAR;
      cnt_next   = '0;
      row_next   = '0;
      col_next   = '0;
    end else begin
      case (state)
        CLEAR: begin
          we_next    = 1'b1;
          waddr_next = cnt;
          din_next   = CHAR_SPACE;
          cnt_next   = cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(ROWS*COLS-1)) begin
            state_next = IDLE;
            cnt_next   = '0;
            top_next   = '0;
            row_next   = '0;
            col_next   = '0;
          end
        end
        IDLE: begin
          if (char_valid) begin
            if (char_in == CHAR_CR) begin
              col_next = '0;
              if (cursor_row < 5'(ROWS-1)) begin
                row_next = cursor_row + 5'd1;
              end else begin
                state_next = SCROLL;
                cnt_next   = '0;
              end
            end else if (char_in >= 7'h20) begin
              // Lower-case codes fold onto upper case; only the low 6 bits are stored.
              we_next    = 1'b1;
              waddr_next = map_addr;
              din_next   = char_in[6:5] == 2'b11 ? char_in[5:0] - 6'h20 : char_in[5:0];
              state_next = WRITE;
            end
          end
        end
        WRITE: begin
          state_next = IDLE;
          if (cursor_col < 6'(COLS-1)) begin
            col_next = cursor_col + 6'd1;
          end else begin
            col_next = '0;
            if (cursor_row < 5'(ROWS-1)) begin
              row_next = cursor_row + 5'd1;
            end else begin
              state_next = SCROLL;
              cnt_next   = '0;
            end
          end
        end
        SCROLL: begin
          we_next    = 1'b1;
          waddr_next = map_addr;
          din_next   = CHAR_SPACE;
          cnt_next   = cnt + ADDR_W'(1);
          if (cnt[5:0] == 6'(COLS-1)) begin
            state_next = IDLE;
            cnt_next   = '0;
            top_next   = (top_row == 5'(ROWS-1)) ? 5'd0 : top_row + 5'd1;
          end
        end
        default: state_next = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= '0;
      top_row    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_din   <= CHAR_SPACE;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      top_row    <= top_next;
      cursor_row <= row_next;
      cursor_col <= col_next;
      vram_we    <= we_next;
      vram_waddr <= waddr_next;
      vram_din   <= din_next;
    end
  end

`ifdef VRAM_TERM_CURSOR_EN
  logic [ADDR_W-1:0] cursor_addr_next;

  // Mapping the next-state cursor keeps cursor_addr aligned with cursor_row/cursor_col.
  vram_addr_map #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor_map (
    .top_row (top_next),
    .row     (row_next),
    .col     (col_next),
    .addr    (cursor_addr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cursor_addr <= '0;
    else     cursor_addr <= cursor_addr_next;
  end
`endif
endmodule
